// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the unified memory port: picks icache or dcache each
// cycle, tracks the owner of every accepted load tag and routes returns to it.
module mem_bus_arbiter #(
  parameter int NUM_TAGS   = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  icache2arb_command,
  input  logic [63:0]                 icache2arb_addr,
  output logic [$clog2(NUM_TAGS)-1:0] arb2icache_response,
  output logic [$clog2(NUM_TAGS)-1:0] arb2icache_tag,
  output logic [63:0]                 arb2icache_data,
  input  logic [1:0]                  dcache2arb_command,
  input  logic [63:0]                 dcache2arb_addr,
  input  logic [63:0]                 dcache2arb_data,
  output logic [$clog2(NUM_TAGS)-1:0] arb2dcache_response,
  output logic [$clog2(NUM_TAGS)-1:0] arb2dcache_tag,
  output logic [63:0]                 arb2dcache_data,
  output logic [1:0]                  proc2mem_command,
  output logic [63:0]                 proc2mem_addr,
  output logic [63:0]                 proc2mem_data,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response,
  input  logic [63:0]                 mem2proc_data,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag,
  output logic                        boost_active,
  output logic                        stray_tag_err
);

  localparam int TW = $clog2(NUM_TAGS);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic {PRIO_D, PRIO_I} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stray_q, stray_d;
  logic          valid_q [NUM_TAGS];
  logic          owner_q [NUM_TAGS];  // 1 = dcache owns the tag

  logic i_req, d_req, sel_i, granted, i_granted, load_accept, ret_hit;

  always_comb begin
    i_req   = icache2arb_command != BUS_NONE;
    d_req   = dcache2arb_command != BUS_NONE;
    sel_i   = (state_q == PRIO_I) ? i_req : (i_req && !d_req);

    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    arb2icache_response = '0;
    arb2dcache_response = '0;
    if (!reset) begin
      if (sel_i) begin
        proc2mem_command    = icache2arb_command;
        proc2mem_addr       = icache2arb_addr;
        arb2icache_response = mem2proc_response;
      end else if (d_req) begin
        proc2mem_command    = dcache2arb_command;
        proc2mem_addr       = dcache2arb_addr;
        proc2mem_data       = dcache2arb_data;
        arb2dcache_response = mem2proc_response;
      end
    end

    granted     = !reset && (sel_i || d_req) && (mem2proc_response != '0);
    i_granted   = granted && sel_i;
    load_accept = granted && (proc2mem_command == BUS_LOAD);

    // Routing looks at the table as it stands this cycle, so a tag being
    // reallocated in the same cycle still reaches its previous owner.
    ret_hit        = !reset && (mem2proc_tag != '0) && valid_q[mem2proc_tag];
    arb2icache_tag = (ret_hit && !owner_q[mem2proc_tag]) ? mem2proc_tag : '0;
    arb2dcache_tag = (ret_hit &&  owner_q[mem2proc_tag]) ? mem2proc_tag : '0;
    arb2icache_data = mem2proc_data;
    arb2dcache_data = mem2proc_data;

    stray_d = stray_q | ((mem2proc_tag != '0) && !ret_hit);

    state_d  = state_q;
    starve_d = starve_q;
    if (!i_req || i_granted) begin
      starve_d = '0;
    end else if (starve_q != SW'(MAX_STARVE)) begin
      starve_d = starve_q + 1'b1;
    end

    case (state_q)
      PRIO_D: begin
        if (i_req && !i_granted && starve_q == SW'(MAX_STARVE - 1)) begin
          state_d  = PRIO_I;
          starve_d = '0;
        end
      end
      PRIO_I: begin
        if (i_granted || !i_req) state_d = PRIO_D;
      end
      default: state_d = PRIO_D;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= PRIO_D;
      starve_q <= '0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      stray_q  <= stray_d;
    end
  end

  // A new allocation takes precedence over a same-cycle return of that tag.
  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q[gi] <= 1'b0;
        owner_q[gi] <= 1'b0;
      end else if (load_accept && mem2proc_response == TW'(gi)) begin
        valid_q[gi] <= 1'b1;
        owner_q[gi] <= !sel_i;
      end else if (ret_hit && mem2proc_tag == TW'(gi)) begin
        valid_q[gi] <= 1'b0;
      end
    end
  end

  assign boost_active  = (state_q == PRIO_I);
  assign stray_tag_err = stray_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by a randomized run
// compared against a tag-ownership / starvation model.
module tb_mem_bus_arbiter;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command, dcache2arb_command, proc2mem_command;
  logic [63:0] icache2arb_addr, dcache2arb_addr, dcache2arb_data;
  logic [63:0] arb2icache_data, arb2dcache_data, proc2mem_addr, proc2mem_data, mem2proc_data;
  logic [3:0]  arb2icache_response, arb2icache_tag, arb2dcache_response, arb2dcache_tag;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic        boost_active, stray_tag_err;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.NUM_TAGS(16), .MAX_STARVE(4)) dut (
    .clock(clock), .reset(reset),
    .icache2arb_command(icache2arb_command), .icache2arb_addr(icache2arb_addr),
    .arb2icache_response(arb2icache_response), .arb2icache_tag(arb2icache_tag),
    .arb2icache_data(arb2icache_data),
    .dcache2arb_command(dcache2arb_command), .dcache2arb_addr(dcache2arb_addr),
    .dcache2arb_data(dcache2arb_data),
    .arb2dcache_response(arb2dcache_response), .arb2dcache_tag(arb2dcache_tag),
    .arb2dcache_data(arb2dcache_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .boost_active(boost_active), .stray_tag_err(stray_tag_err)
  );

  always #5 clock = ~clock;

  // Apply one cycle's inputs and let the combinational outputs settle.
  task automatic drive(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                       input logic [63:0] da, input logic [63:0] dd, input logic [3:0] rsp,
                       input logic [3:0] tg, input logic [63:0] md);
    icache2arb_command = ic; icache2arb_addr = ia;
    dcache2arb_command = dc; dcache2arb_addr = da; dcache2arb_data = dd;
    mem2proc_response = rsp; mem2proc_tag = tg; mem2proc_data = md;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(LOAD, 64'h40, STORE, 64'h80, 64'h99, 4'd3, 4'd5, 64'hCAFE);
    vectors++; if (proc2mem_command !== NONE) begin miscompares++; $display("FAIL rst_cmd got=%0d want=0", proc2mem_command); end
    vectors++; if (arb2icache_response !== 4'd0 || arb2dcache_response !== 4'd0) begin miscompares++; $display("FAIL rst_resp got=%0d/%0d want=0/0", arb2icache_response, arb2dcache_response); end
    vectors++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin miscompares++; $display("FAIL rst_tag got=%0d/%0d want=0/0", arb2icache_tag, arb2dcache_tag); end
    vectors++; if (arb2icache_data !== 64'hCAFE || arb2dcache_data !== 64'hCAFE) begin miscompares++; $display("FAIL rst_data got=%0h/%0h want=cafe", arb2icache_data, arb2dcache_data); end
    tick();
    vectors++; if (boost_active !== 1'b0 || stray_tag_err !== 1'b0) begin miscompares++; $display("FAIL rst_flags got=%b%b want=00", boost_active, stray_tag_err); end
    reset = 1'b0;
    drive(NONE, 0, NONE, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_icache_only();
    drive(LOAD, 64'h100, NONE, 0, 0, 4'd3, 4'd0, 0);
    vectors++; if (arb2icache_response !== 4'd3 || arb2dcache_response !== 4'd0) begin miscompares++; $display("FAIL t1_resp got=%0d/%0d want=3/0", arb2icache_response, arb2dcache_response); end
    vectors++; if (proc2mem_addr !== 64'h100 || proc2mem_command !== LOAD) begin miscompares++; $display("FAIL t1_bus got=%0d@%0h want=1@100", proc2mem_command, proc2mem_addr); end
    tick();
    drive(NONE, 64'h100, NONE, 64'h55, 64'h66, 4'd0, 4'd0, 0);
    vectors++; if (proc2mem_command !== NONE || proc2mem_addr !== 64'h0 || proc2mem_data !== 64'h0) begin miscompares++; $display("FAIL t1_idle got=%0d@%0h d=%0h want=0@0 d=0", proc2mem_command, proc2mem_addr, proc2mem_data); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd3, 64'hDEAD);
    vectors++; if (arb2icache_tag !== 4'd3 || arb2dcache_tag !== 4'd0) begin miscompares++; $display("FAIL t1_ret got=%0d/%0d want=3/0", arb2icache_tag, arb2dcache_tag); end
    vectors++; if (arb2icache_data !== 64'hDEAD) begin miscompares++; $display("FAIL t1_rdata got=%0h want=dead", arb2icache_data); end
    tick();
  endtask

  task automatic test_priority();
    drive(LOAD, 64'h200, LOAD, 64'h300, 0, 4'd5, 4'd0, 0);
    vectors++; if (arb2dcache_response !== 4'd5 || arb2icache_response !== 4'd0) begin miscompares++; $display("FAIL t2_resp got=%0d/%0d want=0/5", arb2icache_response, arb2dcache_response); end
    vectors++; if (proc2mem_addr !== 64'h300) begin miscompares++; $display("FAIL t2_addr got=%0h want=300", proc2mem_addr); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd5, 64'h77);
    vectors++; if (arb2dcache_tag !== 4'd5 || arb2icache_tag !== 4'd0) begin miscompares++; $display("FAIL t2_ret got=%0d/%0d want=0/5", arb2icache_tag, arb2dcache_tag); end
    tick();
  endtask

  task automatic test_starve();
    for (int n = 1; n <= 4; n++) begin
      drive(LOAD, 64'hA00, LOAD, 64'hB00 + 64'(n), 0, 4'(n), 4'd0, 0);
      vectors++; if (boost_active !== 1'b0 || arb2icache_response !== 4'd0 || arb2dcache_response !== 4'(n)) begin miscompares++; $display("FAIL t3_loss%0d got boost=%b i=%0d d=%0d want boost=0 i=0 d=%0d", n, boost_active, arb2icache_response, arb2dcache_response, n); end
      tick();
    end
    drive(LOAD, 64'hA00, LOAD, 64'hB05, 0, 4'd6, 4'd0, 0);
    vectors++; if (boost_active !== 1'b1) begin miscompares++; $display("FAIL t3_boost got=%b want=1", boost_active); end
    vectors++; if (arb2icache_response !== 4'd6 || arb2dcache_response !== 4'd0 || proc2mem_addr !== 64'hA00) begin miscompares++; $display("FAIL t3_igrant got=%0d/%0d@%0h want=6/0@a00", arb2icache_response, arb2dcache_response, proc2mem_addr); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd0, 0);
    vectors++; if (boost_active !== 1'b0) begin miscompares++; $display("FAIL t3_unboost got=%b want=0", boost_active); end
    tick();
  endtask

  task automatic test_busy();
    drive(NONE, 0, LOAD, 64'h500, 0, 4'd0, 4'd0, 0);
    vectors++; if (arb2icache_response !== 4'd0 || arb2dcache_response !== 4'd0 || proc2mem_command !== LOAD) begin miscompares++; $display("FAIL t4_busy got=%0d/%0d cmd=%0d want=0/0 cmd=1", arb2icache_response, arb2dcache_response, proc2mem_command); end
    tick();
    drive(NONE, 0, LOAD, 64'h500, 0, 4'd2, 4'd0, 0);
    vectors++; if (arb2dcache_response !== 4'd2) begin miscompares++; $display("FAIL t4_retry got=%0d want=2", arb2dcache_response); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd2, 64'h22);
    vectors++; if (arb2dcache_tag !== 4'd2 || arb2icache_tag !== 4'd0) begin miscompares++; $display("FAIL t4_ret got=%0d/%0d want=0/2", arb2icache_tag, arb2dcache_tag); end
    tick();
  endtask

  task automatic test_same_cycle_tag();
    drive(LOAD, 64'h600, NONE, 0, 0, 4'd7, 4'd0, 0);
    vectors++; if (arb2icache_response !== 4'd7) begin miscompares++; $display("FAIL t5_alloc got=%0d want=7", arb2icache_response); end
    tick();
    drive(NONE, 0, LOAD, 64'h700, 0, 4'd7, 4'd7, 64'h71);
    vectors++; if (arb2icache_tag !== 4'd7 || arb2dcache_tag !== 4'd0 || arb2dcache_response !== 4'd7) begin miscompares++; $display("FAIL t5_swap got=%0d/%0d resp=%0d want=7/0 resp=7", arb2icache_tag, arb2dcache_tag, arb2dcache_response); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd7, 64'h72);
    vectors++; if (arb2dcache_tag !== 4'd7 || arb2icache_tag !== 4'd0) begin miscompares++; $display("FAIL t5_new got=%0d/%0d want=0/7", arb2icache_tag, arb2dcache_tag); end
    vectors++; if (stray_tag_err !== 1'b0) begin miscompares++; $display("FAIL t5_stray got=%b want=0", stray_tag_err); end
    tick();
  endtask

  task automatic test_reset_stray();
    reset = 1'b1; drive(NONE, 0, NONE, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
    drive(NONE, 0, STORE, 64'h800, 64'h1234, 4'd8, 4'd0, 0);
    vectors++; if (proc2mem_command !== STORE || proc2mem_data !== 64'h1234 || arb2dcache_response !== 4'd8) begin miscompares++; $display("FAIL t6_store got=%0d d=%0h r=%0d want=2 d=1234 r=8", proc2mem_command, proc2mem_data, arb2dcache_response); end
    tick();
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd8, 0);
    vectors++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin miscompares++; $display("FAIL t6_storeret got=%0d/%0d want=0/0", arb2icache_tag, arb2dcache_tag); end
    tick();
    drive(LOAD, 64'h900, NONE, 0, 0, 4'd4, 4'd0, 0);
    vectors++; if (stray_tag_err !== 1'b1) begin miscompares++; $display("FAIL t6_storestray got=%b want=1", stray_tag_err); end
    tick();
    reset = 1'b1;
    drive(NONE, 0, NONE, 0, 0, 0, 0, 0);
    vectors++; if (stray_tag_err !== 1'b0 || boost_active !== 1'b0) begin miscompares++; $display("FAIL t6_asyncrst got=%b%b want=00", stray_tag_err, boost_active); end
    tick();
    reset = 1'b0;
    drive(NONE, 0, NONE, 0, 0, 4'd0, 4'd4, 64'h44);
    vectors++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0 || stray_tag_err !== 1'b0) begin miscompares++; $display("FAIL t6_lost got=%0d/%0d s=%b want=0/0 s=0", arb2icache_tag, arb2dcache_tag, stray_tag_err); end
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(NONE, 0, NONE, 0, 0, 0, 0, 0);
      vectors++; if (stray_tag_err !== 1'b1) begin miscompares++; $display("FAIL t6_sticky%0d got=%b want=1", n, stray_tag_err); end
      tick();
    end
  endtask

  task automatic test_random();
    int owner [16];  // 0 none, 1 icache, 2 dcache
    bit boost, stray, ip, dp, ireq, dreq, pick_i, won, i_won;
    int losses;
    logic [1:0] ic, dc, e_cmd;
    logic [63:0] ia, da, dd, md, e_addr, e_data;
    logic [3:0] rsp, tg, e_ir, e_dr, e_it, e_dt;
    reset = 1'b1; drive(NONE, 0, NONE, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
    foreach (owner[k]) owner[k] = 0;
    boost = 0; stray = 0; losses = 0; ip = 0; dp = 0;
    ic = NONE; dc = NONE; ia = 0; da = 0; dd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ip) begin ic = ($urandom_range(0, 2) == 0) ? NONE : LOAD; ia = {$urandom, $urandom}; end
      if (!dp) begin dc = 2'($urandom_range(0, 2)); da = {$urandom, $urandom}; dd = {$urandom, $urandom}; end
      rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tg  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      md  = {$urandom, $urandom};
      drive(ic, ia, dc, da, dd, rsp, tg, md);
      ireq = (ic != NONE); dreq = (dc != NONE);
      pick_i = boost ? ireq : (ireq && !dreq);
      e_cmd  = pick_i ? ic : dc;
      e_addr = pick_i ? ia : (dreq ? da : 64'h0);
      e_data = (!pick_i && dreq) ? dd : 64'h0;
      e_ir   = pick_i ? rsp : 4'd0;
      e_dr   = (!pick_i && dreq) ? rsp : 4'd0;
      e_it   = (tg != 0 && owner[tg] == 1) ? tg : 4'd0;
      e_dt   = (tg != 0 && owner[tg] == 2) ? tg : 4'd0;
      vectors++; if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr || proc2mem_data !== e_data) begin miscompares++; $display("FAIL rnd%0d_bus got=%0d@%0h d=%0h want=%0d@%0h d=%0h", n, proc2mem_command, proc2mem_addr, proc2mem_data, e_cmd, e_addr, e_data); end
      vectors++; if (arb2icache_response !== e_ir || arb2dcache_response !== e_dr) begin miscompares++; $display("FAIL rnd%0d_resp got=%0d/%0d want=%0d/%0d", n, arb2icache_response, arb2dcache_response, e_ir, e_dr); end
      vectors++; if (arb2icache_tag !== e_it || arb2dcache_tag !== e_dt) begin miscompares++; $display("FAIL rnd%0d_tag got=%0d/%0d want=%0d/%0d", n, arb2icache_tag, arb2dcache_tag, e_it, e_dt); end
      vectors++; if (arb2icache_data !== md || arb2dcache_data !== md) begin miscompares++; $display("FAIL rnd%0d_data got=%0h/%0h want=%0h", n, arb2icache_data, arb2dcache_data, md); end
      vectors++; if (boost_active !== boost || stray_tag_err !== stray) begin miscompares++; $display("FAIL rnd%0d_flags got=%b%b want=%b%b", n, boost_active, stray_tag_err, boost, stray); end
      tick();
      if (tg != 0) begin
        if (owner[tg] == 0) stray = 1;
        owner[tg] = 0;
      end
      won   = (pick_i || dreq) && rsp != 0;
      i_won = pick_i && rsp != 0;
      if (won && e_cmd == LOAD) owner[rsp] = pick_i ? 1 : 2;
      if (boost) begin
        if (!ireq || i_won) begin boost = 0; losses = 0; end
      end else if (!ireq || i_won) begin
        losses = 0;
      end else begin
        losses++;
        if (losses == 4) begin boost = 1; losses = 0; end
      end
      ip = ireq && !i_won;
      dp = dreq && !(won && !pick_i);
    end
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_priority();
    test_starve();
    test_busy();
    test_same_cycle_tag();
    test_reset_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
